// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the delay_line block.
package delay_line_pkg;

  localparam int unsigned MAX_DEPTH = 64;

  // Bits needed to encode values 0..n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_line_fill.sv
// Fill counter for delay_line: counts ce edges since reset or a delay change
// and reports when the line holds eff valid samples.
module delay_line_fill #(
  parameter int DW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [DW-1:0] i_eff,
  output logic          o_primed
);

  logic [DW-1:0] r_dly_q;
  logic [DW-1:0] r_count;
  logic          w_change;

  assign w_change = (i_eff != r_dly_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dly_q <= '0;
      r_count <= '0;
    end else begin
      r_dly_q <= i_eff;
      if (w_change)
        r_count <= '0;
      else if (i_ce && (r_count < i_eff))
        r_count <= r_count + 1'b1;
    end
  end

  // During a change cycle the count is already stale, so treat it as zero.
  assign o_primed = w_change ? (i_eff == '0) : (r_count >= i_eff);

endmodule

// File: rtl/delay_line.sv
// Runtime-selectable delay line with zero-latency bypass and clamped delay.
// Define DELAY_LINE_PRIMED_EN to build the fill counter; otherwise primed is 1.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 10,
  parameter int DW    = int'(clog2(unsigned'(DEPTH + 1)))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [DW-1:0]    dly,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             primed
);

  if (DEPTH < 1 || DEPTH > int'(MAX_DEPTH)) begin : g_bad_depth
    $error("delay_line: DEPTH out of range 1..64");
  end

  localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [DW-1:0]    w_eff;

  assign w_eff = (dly > DEPTH_DW) ? DEPTH_DW : dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (ce) begin
      r_stage[0] <= d;
      for (int unsigned k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // eff=0 passes d straight through; eff=n selects stage n-1.
  always_comb begin
    q = d;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_eff == DW'(k + 1)) q = r_stage[k];
    end
  end

`ifdef DELAY_LINE_PRIMED_EN
  delay_line_fill #(
    .DW(DW)
  ) u_fill (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_ce     (ce),
    .i_eff    (w_eff),
    .o_primed (primed)
  );
`else
  assign primed = 1'b1;
`endif

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line (WIDTH=8, DEPTH=10) against a queue-based model.
module tb_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int DW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ce = 1'b0;
  logic [DW-1:0]    dly = '0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] q;
  logic             primed;

  int total = 0;
  int bad   = 0;

  // Model: newest ce-sample at the front, DEPTH entries deep.
  logic [7:0] hist[$];
  int         m_prev_eff = 0;
  int         m_since    = 0;
  logic [7:0] exp_q;
  logic       exp_primed;

  delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .dly    (dly),
    .d      (d),
    .q      (q),
    .primed (primed)
  );

  always #5 clk = ~clk;

  function automatic int eff_of(input logic [DW-1:0] v);
    return (int'(v) > DEPTH) ? DEPTH : int'(v);
  endfunction

  task automatic apply(input logic rst_v, input logic ce_v, input logic [DW-1:0] dly_v,
                       input logic [7:0] d_v);
    int e;
    reset = rst_v; ce = ce_v; dly = dly_v; d = d_v;
    e = eff_of(dly_v);
    exp_q = (e == 0) ? d_v : hist[e-1];
`ifdef DELAY_LINE_PRIMED_EN
    exp_primed = (e != m_prev_eff) ? (e == 0) : (m_since >= e);
`else
    exp_primed = 1'b1;
`endif
  endtask

  task automatic advance();
    int e;
    @(posedge clk);
    e = eff_of(dly);
    if (reset) begin
      hist = {};
      repeat (DEPTH) hist.push_back(8'h00);
      m_since = 0;
      m_prev_eff = 0;
    end else begin
      if (ce) begin
        hist.push_front(d);
        void'(hist.pop_back());
      end
      if (e != m_prev_eff) m_since = 0;
      else if (ce) m_since++;
      m_prev_eff = e;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 4'd10, 8'h5A); advance();
    apply(1, 0, 4'd10, 8'h3C);
    @(negedge clk);
    total++; if (primed !== exp_primed) begin bad++; $display("FAIL reset_primed_in_reset got=%b want=%b", primed, exp_primed); end
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 4'd10, 8'($urandom));
      @(negedge clk);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q cyc=%0d got=%h want=00", i, q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL reset_primed cyc=%0d got=%b want=%b", i, primed, exp_primed); end
      advance();
    end
  endtask

  task automatic test_fixed_delay();
    apply(1, 0, 4'd10, 8'h00); advance();
    apply(0, 0, 4'd10, 8'h00); advance();
    for (int i = 0; i < 14; i++) begin
      apply(0, 1, 4'd10, 8'(i + 1));
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL fixed_q cyc=%0d got=%h want=%h", i, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL fixed_primed cyc=%0d got=%b want=%b", i, primed, exp_primed); end
      if (i == 10) begin
        total++; if (q !== 8'h01) begin bad++; $display("FAIL fixed_q_10th_edge got=%h want=01", q); end
      end
`ifdef DELAY_LINE_PRIMED_EN
      if (i == 9 || i == 10) begin
        total++; if (primed !== (i == 10)) begin bad++; $display("FAIL fixed_primed_edge cyc=%0d got=%b want=%b", i, primed, (i == 10)); end
      end
`else
      total++; if (primed !== 1'b1) begin bad++; $display("FAIL fixed_primed_const cyc=%0d got=%b want=1", i, primed); end
`endif
      advance();
    end
  endtask

  task automatic test_clock_enable();
    logic [7:0] dv;
    apply(1, 0, 4'd3, 8'h00); advance();
    apply(0, 0, 4'd3, 8'h00); advance();
    for (int i = 0; i < 16; i++) begin
      dv = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 8'hA4));
      apply(0, (i % 4) == 0, 4'd3, dv);
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL ce_q cyc=%0d got=%h want=%h", i, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL ce_primed cyc=%0d got=%b want=%b", i, primed, exp_primed); end
      if (i == 8) begin
        total++; if (q !== 8'h00) begin bad++; $display("FAIL ce_q_early got=%h want=00", q); end
      end
      if (i >= 9 && i <= 12) begin
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL ce_q_hold cyc=%0d got=%h want=a5", i, q); end
      end
      advance();
    end
  endtask

  task automatic test_bypass_clamp();
    logic [7:0] dv;
    for (int i = 0; i < 8; i++) begin
      dv = 8'($urandom);
      apply(0, 1'($urandom), 4'd0, dv);
      @(negedge clk);
      total++; if (q !== dv) begin bad++; $display("FAIL bypass_q cyc=%0d got=%h want=%h", i, q, dv); end
      total++; if (primed !== 1'b1) begin bad++; $display("FAIL bypass_primed cyc=%0d got=%b want=1", i, primed); end
      advance();
    end
    for (int i = 0; i < 14; i++) begin
      apply(0, 1, 4'd15, 8'($urandom));
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL clamp_q cyc=%0d got=%h want=%h", i, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL clamp_primed cyc=%0d got=%b want=%b", i, primed, exp_primed); end
      advance();
    end
    apply(0, 1, 4'd10, 8'($urandom));
    @(negedge clk);
    total++; if (q !== exp_q) begin bad++; $display("FAIL clamp_same_q got=%h want=%h", q, exp_q); end
    total++; if (primed !== 1'b1) begin bad++; $display("FAIL clamp_no_change_primed got=%b want=1", primed); end
    advance();
  endtask

  task automatic test_delay_change();
    logic [7:0] sent[$];
    logic [7:0] dv;
    for (int i = 0; i < 10; i++) begin
      dv = 8'($urandom);
      sent.push_front(dv);
      apply(0, 1, 4'd5, dv);
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL chg_steady_q cyc=%0d got=%h want=%h", i, q, exp_q); end
      advance();
    end
    apply(0, 0, 4'd2, 8'($urandom));
    @(negedge clk);
    total++; if (q !== sent[1]) begin bad++; $display("FAIL chg_q_immediate got=%h want=%h", q, sent[1]); end
    total++; if (primed !== exp_primed) begin bad++; $display("FAIL chg_primed_immediate got=%b want=%b", primed, exp_primed); end
`ifdef DELAY_LINE_PRIMED_EN
    total++; if (primed !== 1'b0) begin bad++; $display("FAIL chg_primed_drop got=%b want=0", primed); end
`endif
    advance();
    for (int j = 1; j <= 4; j++) begin
      apply(0, 1, 4'd2, 8'($urandom));
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL chg_q cyc=%0d got=%h want=%h", j, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL chg_primed cyc=%0d got=%b want=%b", j, primed, exp_primed); end
`ifdef DELAY_LINE_PRIMED_EN
      total++; if (primed !== (j >= 3)) begin bad++; $display("FAIL chg_primed_return cyc=%0d got=%b want=%b", j, primed, (j >= 3)); end
`endif
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] first;
    for (int i = 0; i < 12; i++) begin apply(0, 1, 4'd4, 8'hFF); advance(); end
    apply(1, 1, 4'd4, 8'hFF); advance();
    first = 8'($urandom_range(1, 8'hFE));
    for (int j = 0; j < 8; j++) begin
      apply(0, 1, 4'd4, (j == 0) ? first : 8'($urandom_range(1, 8'hFE)));
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL rst_mid_q cyc=%0d got=%h want=%h", j, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL rst_mid_primed cyc=%0d got=%b want=%b", j, primed, exp_primed); end
      if (j < 4) begin
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_mid_flushed cyc=%0d got=%h want=00", j, q); end
      end
      if (j == 4) begin
        total++; if (q !== first) begin bad++; $display("FAIL rst_mid_first got=%h want=%h", q, first); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dv;
    dv = 4'd6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) dv = DW'($urandom_range(0, 15));
      apply($urandom_range(0, 49) == 0, 1'($urandom), dv, 8'($urandom));
      @(negedge clk);
      total++; if (q !== exp_q) begin bad++; $display("FAIL rand_q cyc=%0d dly=%0d got=%h want=%h", i, dv, q, exp_q); end
      total++; if (primed !== exp_primed) begin bad++; $display("FAIL rand_primed cyc=%0d dly=%0d got=%b want=%b", i, dv, primed, exp_primed); end
      advance();
    end
  endtask

  initial begin
    repeat (DEPTH) hist.push_back(8'h00);
    #1;
    test_reset();
    test_fixed_delay();
    test_clock_enable();
    test_bypass_clamp();
    test_delay_change();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
